// File: rtl/disp_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module  : disp_scan_pkg
// Brief   : Segment patterns, digit-index encoding and BCD helper for disp_scan
// Revision: 1.0
// ============================================================================
package disp_scan_pkg;

  typedef enum logic [1:0] {
    c_DIG_0 = 2'd0,
    c_DIG_1 = 2'd1,
    c_DIG_2 = 2'd2,
    c_DIG_3 = 2'd3
  } digit_idx_e;

  // Active-low patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] c_SEG_0     = 7'h01;
  localparam logic [6:0] c_SEG_1     = 7'h4F;
  localparam logic [6:0] c_SEG_2     = 7'h12;
  localparam logic [6:0] c_SEG_3     = 7'h06;
  localparam logic [6:0] c_SEG_4     = 7'h4C;
  localparam logic [6:0] c_SEG_5     = 7'h24;
  localparam logic [6:0] c_SEG_6     = 7'h20;
  localparam logic [6:0] c_SEG_7     = 7'h0F;
  localparam logic [6:0] c_SEG_8     = 7'h00;
  localparam logic [6:0] c_SEG_9     = 7'h04;
  localparam logic [6:0] c_SEG_E     = 7'h30;
  localparam logic [6:0] c_SEG_MINUS = 7'h7E;
  localparam logic [6:0] c_SEG_BLANK = 7'h7F;

  function automatic logic has_non_bcd(input logic [15:0] value);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (value[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_scan_seg_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg_decode
// Brief   : One BCD digit to active-low 7-segment pattern, with blank/minus
// Revision: 1.0
// ============================================================================
module seg_decode
  import disp_scan_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_minus,
  output logic [6:0] o_seg
);

  // The minus sign sits in a blanked position, so it must win over blank
  always_comb begin
    o_seg = c_SEG_E;
    if (i_minus) begin
      o_seg = c_SEG_MINUS;
    end else if (i_blank) begin
      o_seg = c_SEG_BLANK;
    end else begin
      case (i_digit)
        4'd0:    o_seg = c_SEG_0;
        4'd1:    o_seg = c_SEG_1;
        4'd2:    o_seg = c_SEG_2;
        4'd3:    o_seg = c_SEG_3;
        4'd4:    o_seg = c_SEG_4;
        4'd5:    o_seg = c_SEG_5;
        4'd6:    o_seg = c_SEG_6;
        4'd7:    o_seg = c_SEG_7;
        4'd8:    o_seg = c_SEG_8;
        4'd9:    o_seg = c_SEG_9;
        default: o_seg = c_SEG_E;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/disp_scan.sv
`default_nettype none
// ============================================================================
// Module  : disp_scan
// Brief   : 4-digit multiplexed 7-segment scanner with frame-synchronous load
// Revision: 1.0
// ============================================================================
module disp_scan
  import disp_scan_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] bcd_in,
  input  logic        neg,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  anodes,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        frame_done,
  output logic        err
);

  localparam int              c_PW   = $clog2(CLK_DIV);
  localparam logic [c_PW-1:0] c_PMAX = c_PW'(CLK_DIV - 1);

  logic [c_PW-1:0] r_presc;
  digit_idx_e      r_idx;
  logic [15:0]     r_stage;
  logic [15:0]     r_shadow;
  logic            r_stage_neg;
  logic            r_shadow_neg;
  logic            r_pending;
  logic            r_err;

  logic            w_tick;
  logic            w_boundary;
  logic [3:0]      w_lead;
  logic [3:0]      w_minus;
  logic [3:0]      w_digit;
  logic [6:0]      w_seg;

  assign w_tick     = enable && (r_presc == c_PMAX);
  assign w_boundary = w_tick && (r_idx == c_DIG_0);
  assign frame_done = w_boundary && !reset;
  assign err        = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= c_DIG_3;
    end else if (enable) begin
      r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
      if (w_tick) r_idx <= digit_idx_e'(r_idx - 2'd1);
    end
  end

  // A load on the boundary bypasses staging so it is never left pending
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage      <= '0;
      r_stage_neg  <= 1'b0;
      r_shadow     <= '0;
      r_shadow_neg <= 1'b0;
      r_pending    <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_boundary) begin
      r_pending <= 1'b0;
      if (load) begin
        r_shadow     <= bcd_in;
        r_shadow_neg <= neg;
        r_err        <= has_non_bcd(bcd_in);
      end else if (r_pending) begin
        r_shadow     <= r_stage;
        r_shadow_neg <= r_stage_neg;
        r_err        <= has_non_bcd(r_stage);
      end
    end else if (load) begin
      r_stage     <= bcd_in;
      r_stage_neg <= neg;
      r_pending   <= 1'b1;
    end
  end

  // w_lead[i]: digit i is a leading zero to be blanked; digit 0 is always shown
  assign w_lead[3] = blank_lz && (r_shadow[15:12] == 4'd0);
  assign w_lead[2] = w_lead[3] && (r_shadow[11:8] == 4'd0);
  assign w_lead[1] = w_lead[2] && (r_shadow[7:4] == 4'd0);
  assign w_lead[0] = 1'b0;
  assign w_minus   = {4{r_shadow_neg}} & w_lead & ~{w_lead[2:0], 1'b0};
  assign w_digit   = r_shadow[{r_idx, 2'b00} +: 4];

  seg_decode u_seg_decode (
    .i_digit (w_digit),
    .i_blank (w_lead[r_idx]),
    .i_minus (w_minus[r_idx]),
    .o_seg   (w_seg)
  );

  // The tick cycle registers a dark gap; the new index drives one cycle later
  always_ff @(posedge clk) begin
    if (reset || !enable || w_tick) begin
      anodes   <= 4'hF;
      segments <= c_SEG_BLANK;
      dp       <= 1'b1;
    end else begin
      anodes   <= ~(4'b0001 << r_idx);
      segments <= w_seg;
      dp       <= !(r_shadow_neg && !w_lead[3] && (r_idx == c_DIG_3));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_disp_scan
// Brief   : Self-checking bench for disp_scan against a frame-level model
// Revision: 1.0
// ============================================================================
module tb_disp_scan;

  localparam int D = 4;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        enable   = 1'b0;
  logic [15:0] bcd_in   = '0;
  logic        neg      = 1'b0;
  logic        load     = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic        frame_done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  disp_scan #(.CLK_DIV(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bcd_in     (bcd_in),
    .neg        (neg),
    .load       (load),
    .blank_lz   (blank_lz),
    .anodes     (anodes),
    .segments   (segments),
    .dp         (dp),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [6:0] seg_pat(input int v);
    case (v)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b0110000;
    endcase
  endfunction

  function automatic bit non_bcd(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void exp_digit(input logic [15:0] sh, input bit ng, input bit blz,
                                    input int idx, output logic [6:0] s, output logic d);
    int nb;
    int p;
    nb = 0;
    p  = 3;
    while (blz && p >= 1 && sh[p*4 +: 4] == 4'd0) begin
      nb++;
      p--;
    end
    if (idx >= 4 - nb) s = (ng && idx == 4 - nb) ? 7'b1111110 : 7'b1111111;
    else               s = seg_pat(int'(sh[idx*4 +: 4]));
    d = !(ng && nb == 0 && idx == 3);
  endfunction

  int          m_en_cnt;
  int          m_ticks;
  logic [15:0] m_stage;
  logic [15:0] m_shadow;
  bit          m_stage_neg, m_neg, m_pending, m_err;
  bit          m_started = 1'b0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  always @(posedge clk) begin
    int idx;
    bit tick;
    if (reset) begin
      m_started = 1'b1;
      m_en_cnt = 0; m_ticks = 0;
      m_stage = '0; m_shadow = '0;
      m_stage_neg = 0; m_neg = 0; m_pending = 0; m_err = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      idx  = 3 - (m_ticks % 4);
      tick = enable && (m_en_cnt % D == D - 1);
      if (!enable || tick) begin
        e_an = 4'hF;
      end else begin
        e_an = ~(4'b0001 << idx);
        exp_digit(m_shadow, m_neg, blank_lz, idx, e_seg, e_dp);
      end
      if (tick && idx == 0) begin
        if (load) begin
          m_shadow = bcd_in; m_neg = neg; m_err = non_bcd(bcd_in);
        end else if (m_pending) begin
          m_shadow = m_stage; m_neg = m_stage_neg; m_err = non_bcd(m_stage);
        end
        m_pending = 0;
      end else if (load) begin
        m_stage = bcd_in; m_stage_neg = neg; m_pending = 1;
      end
      if (enable) m_en_cnt++;
      if (tick)   m_ticks++;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("anodes", 16'(anodes), 16'(e_an));
      if (e_an != 4'hF) begin
        chk("segments", 16'(segments), 16'(e_seg));
        chk("dp", 16'(dp), 16'(e_dp));
      end
      chk("err", 16'(err), 16'(m_err));
      chk("frame_done", 16'(frame_done),
          16'(!reset && enable && (m_en_cnt % D == D - 1) && (m_ticks % 4 == 3)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (frame_done !== 1'b1) timeout("wait_frame_done");
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n;
    n = 0;
    @(negedge clk);
    while (anodes !== target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (anodes !== target) timeout("wait_anodes");
  endtask

  task automatic load_val(input logic [15:0] v, input bit n_in);
    @(posedge clk); #1;
    load = 1'b1; bcd_in = v; neg = n_in;
    cyc(1);
    load = 1'b0;
  endtask

  function automatic logic [15:0] rnd_bcd();
    logic [15:0] v;
    int r;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)       v[i*4 +: 4] = 4'd0;
      else if (r == 9) v[i*4 +: 4] = 4'($urandom_range(10, 15));
      else             v[i*4 +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    cyc(2);
    @(negedge clk);
    chk("rst_anodes", 16'(anodes), 16'h000F);
    chk("rst_segments", 16'(segments), 16'h007F);
    chk("rst_dp", 16'(dp), 16'h0001);
    chk("rst_frame_done", 16'(frame_done), 16'h0000);
    chk("rst_err", 16'(err), 16'h0000);

    // Plain 1234, gap before each digit
    @(posedge clk); #1;
    reset = 1'b0; enable = 1'b1; load = 1'b1; bcd_in = 16'h1234;
    cyc(1);
    load = 1'b0;
    wait_fd();
    @(negedge clk);
    chk("gap_anodes", 16'(anodes), 16'h000F);
    @(negedge clk);
    chk("d3_anodes", 16'(anodes), 16'h0007);
    chk("d3_seg_1", 16'(segments), 16'h004F);
    wait_an(4'b1011); chk("d2_seg_2", 16'(segments), 16'h0012);
    wait_an(4'b1101); chk("d1_seg_3", 16'(segments), 16'h0006);
    wait_an(4'b1110); chk("d0_seg_4", 16'(segments), 16'h004C);

    // -42 with leading-zero blanking
    blank_lz = 1'b1;
    load_val(16'h0042, 1'b1);
    wait_fd();
    wait_an(4'b0111); chk("neg_d3_dark", 16'(segments), 16'h007F); chk("neg_d3_dp", 16'(dp), 16'h0001);
    wait_an(4'b1011); chk("neg_d2_minus", 16'(segments), 16'h007E); chk("neg_d2_dp", 16'(dp), 16'h0001);
    wait_an(4'b1101); chk("neg_d1_4", 16'(segments), 16'h004C);
    wait_an(4'b1110); chk("neg_d0_2", 16'(segments), 16'h0012); chk("neg_d0_dp", 16'(dp), 16'h0001);

    // Latest load before the boundary wins
    blank_lz = 1'b0; neg = 1'b0;
    wait_fd();
    cyc(3);
    load = 1'b1; bcd_in = 16'h1000;
    cyc(1);
    load = 1'b0;
    cyc(4);
    load = 1'b1; bcd_in = 16'h2000;
    cyc(1);
    load = 1'b0;
    wait_fd();
    wait_an(4'b0111); chk("latest_d3_2", 16'(segments), 16'h0012);
    wait_an(4'b1110); chk("latest_d0_0", 16'(segments), 16'h0001);

    // Non-BCD digit sets err, a clean update clears it
    load_val(16'h00A5, 1'b0);
    wait_fd();
    @(negedge clk); chk("err_set", 16'(err), 16'h0001);
    wait_an(4'b1101); chk("d1_E", 16'(segments), 16'h0030);
    load_val(16'h0005, 1'b0);
    wait_fd();
    @(negedge clk); chk("err_clear", 16'(err), 16'h0000);

    // Enable low darkens on the next cycle, then resumes
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk); chk("disable_dark", 16'(anodes), 16'h000F);
    cyc(5);
    enable = 1'b1;

    // Load on the boundary, then reset mid-frame
    wait_fd();
    #1;
    load = 1'b1; bcd_in = 16'h9876;
    @(posedge clk); #1;
    load = 1'b0;
    cyc(5);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_anodes", 16'(anodes), 16'h000F);
    chk("midrst_segments", 16'(segments), 16'h007F);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_an(4'b0111); chk("post_rst_d3_0", 16'(segments), 16'h0001);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      load   = ($urandom_range(0, 5) == 0);
      bcd_in = rnd_bcd();
      neg    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      enable = ($urandom_range(0, 19) != 0);
      reset  = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    load = 1'b0; reset = 1'b0;
    cyc(3);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 50000, giving the number of clk cycles each digit is driven; legal values are 2 or greater.
REQ-002 Port clk, input, 1: the single system clock; all logic SHALL be on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port enable, input, 1: scan enable; while low, the prescaler and digit index SHALL hold and all digits SHALL be dark.
REQ-005 Port bcd_in, input, 16: four BCD digits, with [15:12] the most significant digit (digit 3) and [3:0] digit 0.
REQ-006 Port neg, input, 1: the result is negative (ALU special signal).
REQ-007 Port load, input, 1: single-cycle request to capture bcd_in and neg.
REQ-008 Port blank_lz, input, 1: enables leading-zero blanking.
REQ-009 Port anodes, output, 4: active-low digit enables, at most one bit low; anodes[3] drives the leftmost digit.
REQ-010 Port segments, output, 7: active-low segments, ordered {a,b,c,d,e,f,g}.
REQ-011 Port dp, output, 1: active-low decimal point.
REQ-012 Port frame_done, output, 1: one-cycle pulse at each frame boundary.
REQ-013 Port err, output, 1: sticky flag indicating a non-BCD digit in the displayed value.

Function
REQ-014 The prescaler SHALL count 0..CLK_DIV-1 while enable is high and SHALL assert tick on the cycle its count equals CLK_DIV-1, then wrap to 0.
REQ-015 On each tick, the digit index SHALL advance 3->2->1->0->3.
REQ-016 A frame boundary is a tick with index 0; frame_done SHALL pulse high for exactly that cycle.
REQ-017 On load, bcd_in and neg SHALL be captured into staging registers; a later load before the boundary overwrites them (latest wins).
REQ-018 The shadow registers SHALL update only at a frame boundary, and only if a load is pending; the pending flag SHALL clear on that update.
REQ-019 If load coincides with a boundary, that cycle's bcd_in and neg SHALL go directly to shadow and no load SHALL remain pending.
REQ-020 anodes, segments and dp SHALL be registered and SHALL reflect the new index one cycle after the tick.
REQ-021 On the cycle after every tick, anodes SHALL be 4'b1111 (anti-ghost gap); the new digit SHALL drive from the following cycle.
REQ-022 Digit values 0-9 SHALL decode to standard 7-segment patterns; values 10-15 SHALL show "E" (a,d,e,f,g lit).
REQ-023 Blanking: with blank_lz=1, each zero digit of 3..1 that has only zeros to its left SHALL be dark (segments 7'h7F); digit 0 SHALL never blank.
REQ-024 Sign: with neg=1 in shadow, the leftmost blanked position adjacent to the first shown digit SHALL show "-" (g only).
REQ-025 Sign: if no position is blanked, dp SHALL be lit on digit 3 instead; dp SHALL otherwise be high.
REQ-026 err SHALL set when a shadow update contains any digit greater than 9.
REQ-027 err SHALL clear only on reset or on a shadow update with all digits valid.
REQ-028 When enable deasserts, anodes SHALL go 4'b1111 on the next cycle.
REQ-029 When enable reasserts, scanning SHALL resume from the held index and prescaler count.

Reset
REQ-030 On reset, the prescaler, staging, shadow, pending and err SHALL be 0, and the index SHALL be 3.
REQ-031 On reset, anodes SHALL be 4'b1111, segments 7'h7F, dp 1 and frame_done 0.
REQ-032 Reset SHALL take priority over load and enable on the same cycle; a load pending at reset SHALL be discarded.

Structure
REQ-033 Package disp_scan_pkg SHALL hold the segment pattern constants (digits 0-9, "E", "-", blank) and the digit-index encoding.
REQ-034 Sub-module seg_decode (combinational, 4-bit digit plus blank/minus controls to 7 segments) SHALL be instantiated once.

Verification (CLK_DIV=4)
REQ-035 Scenario: reset, enable=1, load 16'h1234, blank_lz=0 -> after the first frame boundary, the bench observes anodes 0111/"1", 1011/"2", 1101/"3", 1110/"4", each preceded by a one-cycle 1111 gap.
REQ-036 Scenario: load 16'h0042, neg=1, blank_lz=1 -> digit 3 dark, digit 2 "-", digit 1 "4", digit 0 "2", dp high on all digits.
REQ-037 Scenario: load 16'h1000 mid-frame, then load 16'h2000 before the boundary -> the next frame shows "2000", and "1000" never appears.
REQ-038 Scenario: load 16'h00A5 -> digit 1 shows "E" and err=1; then load 16'h0005 -> err=0 after the next boundary.
REQ-039 Scenario: load asserted on the boundary cycle, then reset asserted mid-frame -> outputs are dark next cycle, and after release shadow=0 and digit 3 is scanned first.
